// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/writeback,
// with memory-ready stalls (when MEM_HANDSHAKE=1) and a wrapping retired-instruction counter.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int INSTRET_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [2:0]           imm_src,
  output logic                 reg_write,
  output logic                 illegal_instr,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_ready;
  logic                 w_taken;
  logic                 w_retire;
  logic                 w_pc_write;
  logic                 w_ir_write;
  logic                 w_mem_write;
  logic                 w_reg_write;
  logic                 w_illegal;

  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + INSTRET_ONE;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_retire    = 1'b0;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = w_ready;
        w_pc_write = w_ready;
        w_next     = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH can compare while it sits in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = w_ready;
        w_next      = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = w_taken;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        w_next    = S_ALUWB;
      end
      S_ILLEGAL: w_illegal = 1'b1;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      OP_LUI:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  // Reset masks the enables so FETCH's ready-driven writes cannot leak out during reset.
  assign pc_write      = w_pc_write  & rst_n;
  assign ir_write      = w_ir_write  & rst_n;
  assign mem_write     = w_mem_write & rst_n;
  assign reg_write     = w_reg_write & rst_n;
  assign illegal_instr = w_illegal   & rst_n;
  assign state         = r_state;
  assign instret       = r_instret;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-phase model checked every cycle,
// plus literal checks on counters, stalls, reset, wrap and no-handshake CPI.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       a_pc_write, a_adr_src, a_mem_write, a_ir_write, a_reg_write, a_illegal;
  logic [1:0] a_result_src, a_src_a, a_src_b, a_alu_op;
  logic [2:0] a_imm_src;
  logic [3:0] a_state;
  logic [3:0] a_instret;

  logic        b_rst_n;
  logic [6:0]  b_op;
  logic        b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write, b_illegal;
  logic [1:0]  b_result_src, b_src_a, b_src_b, b_alu_op;
  logic [2:0]  b_imm_src;
  logic [3:0]  b_state;
  logic [31:0] b_instret;

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1), .INSTRET_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(a_pc_write), .adr_src(a_adr_src), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .result_src(a_result_src), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .alu_op(a_alu_op),
    .imm_src(a_imm_src), .reg_write(a_reg_write), .illegal_instr(a_illegal),
    .state(a_state), .instret(a_instret)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0), .INSTRET_W(32)) dut_nohs (
    .clk(clk), .rst_n(b_rst_n), .op(b_op), .funct3(funct3), .zero(zero), .mem_ready(1'b0),
    .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .result_src(b_result_src), .alu_src_a(b_src_a), .alu_src_b(b_src_b), .alu_op(b_alu_op),
    .imm_src(b_imm_src), .reg_write(b_reg_write), .illegal_instr(b_illegal),
    .state(b_state), .instret(b_instret)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Datapath selects each phase must present: {adr_src, result_src, alu_src_a, alu_src_b, alu_op}.
  function automatic logic [8:0] ctrl_of(int s);
    case (s)
      0:  return 9'b0_10_00_10_00;
      1:  return 9'b0_00_01_01_00;
      2:  return 9'b0_00_10_01_00;
      3:  return 9'b1_00_00_00_00;
      4:  return 9'b0_01_00_00_00;
      5:  return 9'b1_00_00_00_00;
      6:  return 9'b0_00_10_00_10;
      7:  return 9'b0_00_10_01_10;
      9:  return 9'b0_00_10_00_01;
      10: return 9'b0_00_01_10_00;
      11: return 9'b0_00_11_01_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic int imm_of(logic [6:0] o);
    case (o)
      OP_SW:  return 1;
      OP_BR:  return 2;
      OP_JAL: return 3;
      OP_LUI: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int cpi_of(logic [6:0] o);
    case (o)
      OP_LW:  return 5;
      OP_SW, OP_R, OP_I, OP_JAL, OP_LUI: return 4;
      default: return 3;
    endcase
  endfunction

  // Model: an instruction is a list of phases after DECODE; it retires when its last phase ends.
  int m_state   = 0;
  int m_instret = 0;
  int plan[$];
  int n_mw = 0, n_ill = 0, n_ir = 0, n_wen = 0, n_rw = 0, n_brpc = 0, n_stall = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_state", int'(a_state), 0);
      chk("reset_enables", int'({a_pc_write, a_ir_write, a_mem_write, a_reg_write, a_illegal}), 0);
      chk("reset_instret", int'(a_instret), 0);
      m_state   = 0;
      m_instret = 0;
      plan.delete();
    end else begin
      logic taken;
      logic [4:0] exp_en;
      taken  = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? !zero : 1'b0;
      exp_en = {(m_state == 0 && mem_ready) || m_state == 10 || (m_state == 9 && taken),
                m_state == 0 && mem_ready,
                m_state == 5,
                m_state == 4 || m_state == 8,
                m_state == 12};
      chk("state", int'(a_state), m_state);
      chk("selects", int'({a_adr_src, a_result_src, a_src_a, a_src_b, a_alu_op}), int'(ctrl_of(m_state)));
      chk("enables", int'({a_pc_write, a_ir_write, a_mem_write, a_reg_write, a_illegal}), int'(exp_en));
      chk("imm_src", int'(a_imm_src), imm_of(op));
      chk("instret", int'(a_instret), m_instret % 16);

      n_mw    += int'(a_mem_write);
      n_ill   += int'(a_illegal);
      n_ir    += int'(a_ir_write);
      n_rw    += int'(a_reg_write);
      n_wen   += int'(a_mem_write | a_reg_write);
      n_brpc  += int'(a_pc_write && a_state == 4'd9);
      n_stall += int'(a_state == 4'd0 && !a_ir_write);

      if (m_state == 0) begin
        if (mem_ready) m_state = 1;
      end else if (m_state == 1) begin
        plan.delete();
        case (op)
          OP_LW:  plan = '{2, 3, 4};
          OP_SW:  plan = '{2, 5};
          OP_R:   plan = '{6, 8};
          OP_I:   plan = '{7, 8};
          OP_BR:  plan = '{9};
          OP_JAL: plan = '{10, 8};
          OP_LUI: plan = '{11, 8};
          default: plan = '{12};
        endcase
        m_state = plan.pop_front();
      end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
        m_state = m_state;
      end else if (plan.size() == 0) begin
        if (m_state != 12) m_instret++;
        m_state = 0;
      end else begin
        m_state = plan.pop_front();
      end
    end
  end

  // Starts with the DUT in FETCH; fw stalled fetch cycles, mw stalled memory cycles.
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic z, input int fw, input int mw);
    int total;
    op     = o;
    funct3 = f3;
    zero   = z;
    total  = cpi_of(o) + fw + mw;
    for (int i = 0; i < total; i++) begin
      mem_ready = !(i < fw || (i >= fw + 3 && i < fw + 3 + mw));
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, n;
    logic [6:0] b_ops [8];
    int         b_cpi [8];
    b_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI, OP_BAD};
    b_cpi = '{5, 4, 4, 4, 3, 4, 4, 3};

    rst_n = 1'b0; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000; zero = 1'b0;
    b_rst_n = 1'b0; b_op = OP_R;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(OP_LW, 3'b010, 1'b0, 0, 0);
    chk("lw_instret", int'(a_instret), 1);

    s0 = n_mw;
    run(OP_SW, 3'b010, 1'b0, 0, 3);
    chk("sw_mem_write_cycles", n_mw - s0, 4);
    chk("sw_instret", int'(a_instret), 2);

    s0 = n_brpc; run(OP_BR, 3'b000, 1'b1, 0, 0); chk("beq_taken", n_brpc - s0, 1);
    s0 = n_brpc; run(OP_BR, 3'b000, 1'b0, 0, 0); chk("beq_not_taken", n_brpc - s0, 0);
    s0 = n_brpc; run(OP_BR, 3'b001, 1'b0, 0, 0); chk("bne_taken", n_brpc - s0, 1);
    chk("branch_instret", int'(a_instret), 5);

    s0 = n_ill; s1 = n_wen;
    run(OP_BAD, 3'b000, 1'b0, 0, 0);
    chk("illegal_pulse_cycles", n_ill - s0, 1);
    chk("illegal_no_writes", n_wen - s1, 0);
    chk("illegal_instret", int'(a_instret), 5);

    s0 = n_ir; s1 = n_stall;
    run(OP_R, 3'b000, 1'b0, 5, 0);
    chk("fetch_stall_ir_write", n_ir - s0, 1);
    chk("fetch_stall_cycles", n_stall - s1, 5);

    run(OP_I, 3'b000, 1'b0, 0, 0);
    run(OP_LUI, 3'b000, 1'b0, 0, 0);
    run(OP_JAL, 3'b000, 1'b0, 0, 0);
    s0 = n_brpc;
    run(OP_BR, 3'b001, 1'b1, 0, 0);
    run(OP_BR, 3'b100, 1'b1, 0, 0);
    chk("branch_other_not_taken", n_brpc - s0, 0);
    chk("mixed_instret", int'(a_instret), 11);

    op = OP_LW; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #2;
    chk("pre_reset_memread", int'(a_state), 3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", int'(a_state), 0);
    chk("async_reset_instret", int'(a_instret), 0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    rst_n = 1'b1;
    s2 = n_rw;
    run(OP_R, 3'b000, 1'b0, 0, 0);
    chk("post_reset_reg_writes", n_rw - s2, 1);
    chk("post_reset_instret", int'(a_instret), 1);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) run(OP_R, 3'b000, 1'b0, 0, 0);
    chk("instret_wrap", int'(a_instret), 1);

    for (int k = 0; k < 8; k++) begin
      b_op = b_ops[k];
      b_rst_n = 1'b0;
      #1;
      b_rst_n = 1'b1;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (b_state != 4'd0 && n < 20);
      chk("nohs_cpi", n, b_cpi[k]);
      chk("nohs_instret", int'(b_instret), (k == 7) ? 0 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
